// File: rtl/hockey_game_sequencer.sv
// hockey_game_sequencer
// Match controller for VGA air-hockey. Walks the game through idle, serve,
// play, goal freeze, pause and game-over phases. It keeps both scores, picks
// the serve direction and issues a one-cycle serve pulse. All timing is
// counted in frames: the phase counter only advances on vSyncStart.

module hockey_game_sequencer #(
  parameter logic [7:0] SERVE_FRAMES = 8'd60,
  parameter logic [7:0] GOAL_FRAMES  = 8'd90,
  parameter logic [7:0] FLASH_FRAMES = 8'd30,
  parameter logic [3:0] WIN_SCORE    = 4'd7,
  parameter int         START_BIT    = 3
) (
  input  logic       pixelClock,
  input  logic       resetN,
  input  logic       vSyncStart,
  input  logic [7:0] buttons,
  input  logic       goalLeft,
  input  logic       goalRight,
  output logic       paddleEnable,
  output logic       puckEnable,
  output logic       puckServe,
  output logic       serveDir,
  output logic [3:0] scoreLeft,
  output logic [3:0] scoreRight,
  output logic [2:0] phase,
  output logic       winner,
  output logic       flashOn
);

  // Phase codes are visible on the HUD port, so the encoding is fixed.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_GOAL  = 3'd3,
    ST_PAUSE = 3'd4,
    ST_OVER  = 3'd5
  } state_e;

  // Terminal counts: a phase that lasts N frames ends on the frame where the
  // counter, cleared at entry, reads N-1.
  localparam logic [7:0] SERVE_LAST = SERVE_FRAMES - 8'd1;
  localparam logic [7:0] GOAL_LAST  = GOAL_FRAMES  - 8'd1;
  localparam logic [7:0] FLASH_LAST = FLASH_FRAMES - 8'd1;

  state_e     state_q,      state_d;
  logic [7:0] cnt_q,        cnt_d;
  logic [3:0] score_l_q,    score_l_d;
  logic [3:0] score_r_q,    score_r_d;
  logic       dir_q,        dir_d;
  logic       winner_q,     winner_d;
  logic       flash_q,      flash_d;
  logic       serve_q,      serve_d;
  logic       paddle_en_q,  paddle_en_d;
  logic       puck_en_q,    puck_en_d;
  logic       start_hist_q, start_hist_d;

  logic       start_press;
  logic       buttons_unused;

  // Only the Start bit of the pad matters to the sequencer.
  assign buttons_unused = ^buttons;

  // Start counts once per frame-sampled rising edge, so holding the button
  // across several frames produces a single press.
  assign start_press = vSyncStart & buttons[START_BIT] & ~start_hist_q;

  // Next-state and next-output logic for the whole match sequencer.
  always_comb begin
    // NOTE: every _d signal is given its hold value first so no path through
    // the case statement leaves it unassigned, which would infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    score_l_d    = score_l_q;
    score_r_d    = score_r_q;
    dir_d        = dir_q;
    winner_d     = winner_q;
    flash_d      = flash_q;
    serve_d      = 1'b0;
    start_hist_d = start_hist_q;

    if (vSyncStart) begin
      start_hist_d = buttons[START_BIT];
    end

    case (state_q)
      ST_IDLE: begin
        if (start_press) begin
          score_l_d = 4'd0;
          score_r_d = 4'd0;
          cnt_d     = 8'd0;
          state_d   = ST_SERVE;
        end
      end

      ST_SERVE: begin
        // Start is deliberately ignored while the serve countdown runs.
        if (vSyncStart) begin
          if (cnt_q == SERVE_LAST) begin
            serve_d = 1'b1;
            cnt_d   = 8'd0;
            state_d = ST_PLAY;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      ST_PLAY: begin
        // A goal beats a simultaneous Start. A right-goal beats a
        // simultaneous left-goal. The next serve goes toward the player who
        // conceded.
        if (goalRight) begin
          if (score_l_q != WIN_SCORE) begin
            score_l_d = score_l_q + 4'd1;
          end
          dir_d   = 1'b1;
          cnt_d   = 8'd0;
          state_d = ST_GOAL;
        end else if (goalLeft) begin
          if (score_r_q != WIN_SCORE) begin
            score_r_d = score_r_q + 4'd1;
          end
          dir_d   = 1'b0;
          cnt_d   = 8'd0;
          state_d = ST_GOAL;
        end else if (start_press) begin
          cnt_d   = 8'd0;
          state_d = ST_PAUSE;
        end
      end

      ST_PAUSE: begin
        // Resume straight into play; the puck keeps its position, no re-serve.
        if (start_press) begin
          cnt_d   = 8'd0;
          state_d = ST_PLAY;
        end
      end

      ST_GOAL: begin
        if (vSyncStart) begin
          if (cnt_q == GOAL_LAST) begin
            cnt_d = 8'd0;
            if (score_l_q == WIN_SCORE) begin
              winner_d = 1'b0;
              state_d  = ST_OVER;
            end else if (score_r_q == WIN_SCORE) begin
              winner_d = 1'b1;
              state_d  = ST_OVER;
            end else begin
              state_d  = ST_SERVE;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      ST_OVER: begin
        // The winner stays on the HUD into the next match until reset.
        if (start_press) begin
          score_l_d = 4'd0;
          score_r_d = 4'd0;
          flash_d   = 1'b0;
          cnt_d     = 8'd0;
          state_d   = ST_SERVE;
        end else if (vSyncStart) begin
          if (cnt_q == FLASH_LAST) begin
            flash_d = ~flash_q;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      default: begin
        // Unused codes recover to IDLE on the next cycle.
        cnt_d   = 8'd0;
        state_d = ST_IDLE;
      end
    endcase

    // Enables are decoded from the next state so they line up with phase.
    paddle_en_d = (state_d == ST_SERVE) || (state_d == ST_PLAY);
    puck_en_d   = (state_d == ST_PLAY);
  end

  // State and registered outputs, with synchronous active-low reset.
  always_ff @(posedge pixelClock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge, whatever the statement order.
    if (!resetN) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 8'd0;
      score_l_q    <= 4'd0;
      score_r_q    <= 4'd0;
      dir_q        <= 1'b1;
      winner_q     <= 1'b0;
      flash_q      <= 1'b0;
      serve_q      <= 1'b0;
      paddle_en_q  <= 1'b0;
      puck_en_q    <= 1'b0;
      start_hist_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
      dir_q        <= dir_d;
      winner_q     <= winner_d;
      flash_q      <= flash_d;
      serve_q      <= serve_d;
      paddle_en_q  <= paddle_en_d;
      puck_en_q    <= puck_en_d;
      start_hist_q <= start_hist_d;
    end
  end

  assign paddleEnable = paddle_en_q;
  assign puckEnable   = puck_en_q;
  assign puckServe    = serve_q;
  assign serveDir     = dir_q;
  assign scoreLeft    = score_l_q;
  assign scoreRight   = score_r_q;
  assign phase        = state_q;
  assign winner       = winner_q;
  assign flashOn      = flash_q;

endmodule
